// File: rtl/dco_phase_pkg.sv
// Shared types and helpers for the DCO phase tracker family.
// Provides the tracker FSM encoding, the signed clamp and phase-width derivation.
package dco_phase_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      TRACK
   } trk_state_t;

   // Width of the fractional stage index: one DCO period spans 2*numStages steps
   function automatic int calc_fw(input int numStages);
      return $clog2(2 * numStages);
   endfunction

   function automatic int calc_phw(input int cntw, input int numStages);
      return cntw + calc_fw(numStages);
   endfunction

   function automatic longint sat_signed(input longint value, input int width);
      longint maxVal;
      longint minVal;
      maxVal = (longint'(1) <<< (width - 1)) - 1;
      minVal = -(longint'(1) <<< (width - 1));
      if (value > maxVal) begin
         return maxVal;
      end
      if (value < minVal) begin
         return minVal;
      end
      return value;
   endfunction

endpackage

// File: rtl/dco_phase_tracker_if.sv
// Phase-error delivery bus between the tracker and the digital loop filter.
// The master presents err/err_sat qualified by err_valid; the slave accepts with err_ready.
interface dco_phase_tracker_if #(
   parameter int ERRW = 16
);
   logic [ERRW-1:0] err;
   logic            err_valid;
   logic            err_ready;
   logic            err_sat;

   modport master (
      output err,
      output err_valid,
      output err_sat,
      input  err_ready
   );

   modport slave (
      input  err,
      input  err_valid,
      input  err_sat,
      output err_ready
   );
endinterface

// File: rtl/refclk_edge_sync.sv
// Brings an asynchronous reference clock into the pclk domain and emits a one-cycle
// pulse per rising edge; the pulse appears SYNC_STAGES+1 pclk cycles after the edge.
module refclk_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic pclk,
   input  logic resetn,
   input  logic i_async,
   output logic o_evt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_evt;

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_evt  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_evt  <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign o_evt = r_evt;

endmodule

// File: rtl/dco_phase_tracker.sv
// DCO phase tracker: samples the DCO phase on each synchronised refclk edge and reports
// target-minus-measured error. Define PHASE_FREQ_MEAS_EN to build the o_freq_meas path.
module dco_phase_tracker
   import dco_phase_pkg::*;
#(
   parameter int NUM_STAGES  = 5,
   parameter int CNTW        = 16,
   parameter int DIVW        = 10,
   parameter int ERRW        = 16,
   parameter int BRAKE_DELTA = 50,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           pclk,
   input  logic                           resetn,
   input  logic                           i_refclk,
   input  logic                           i_enable,
   input  logic [calc_fw(NUM_STAGES)-1:0] i_frac_state,
   input  logic [DIVW-1:0]                i_divn,
   input  logic                           i_brake,
   dco_phase_tracker_if.master            errBus,
   output logic                           o_overrun,
   output logic [1:0]                     o_locked_state,
   output logic [ERRW-1:0]                o_freq_meas
);

   localparam int             PHW             = calc_phw(CNTW, NUM_STAGES);
   localparam logic [PHW-1:0] STEPS_PER_CYCLE = PHW'(2 * NUM_STAGES);
   localparam logic [PHW-1:0] BRAKE_STEPS     = PHW'(BRAKE_DELTA);

   logic            w_evt;
   logic [PHW-1:0]  r_cycleSteps;
   logic [PHW-1:0]  w_phase;
   logic [PHW-1:0]  w_step;
   logic [PHW-1:0]  w_diff;
   logic [PHW-1:0]  r_target;
   longint          w_errFull;
   longint          w_errClamp;
   trk_state_t      r_state;
   logic [ERRW-1:0] r_err;
   logic            r_errValid;
   logic            r_errSat;
   logic            r_overrun;

   refclk_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_refclkSync (
      .pclk   (pclk),
      .resetn (resetn),
      .i_async(i_refclk),
      .o_evt  (w_evt)
   );

   // The cycle count is held pre-scaled by 2*NUM_STAGES so it wraps on the 2^PHW phase
   // modulus; scaling a wrapped counter instead would jump at wrap when 2*NUM_STAGES is not a power of two.
   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         r_cycleSteps <= '0;
      end else begin
         r_cycleSteps <= r_cycleSteps + STEPS_PER_CYCLE;
      end
   end

   always_comb begin
      w_phase    = r_cycleSteps + PHW'(i_frac_state);
      w_step     = PHW'(i_divn) * STEPS_PER_CYCLE - (i_brake ? BRAKE_STEPS : '0);
      w_diff     = r_target - w_phase;
      w_errFull  = longint'($signed(w_diff));
      w_errClamp = sat_signed(w_errFull, ERRW);
   end

   // Acceptance clears valid first so a coincident refclk sample can re-assert it;
   // dropping enable overrides everything, including a same-cycle sample.
   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_target   <= '0;
         r_err      <= '0;
         r_errValid <= 1'b0;
         r_errSat   <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (r_errValid && errBus.err_ready) begin
            r_errValid <= 1'b0;
         end
         if (!i_enable) begin
            r_state    <= IDLE;
            r_errValid <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= INIT;
               end
               INIT: begin
                  if (w_evt) begin
                     r_target <= w_phase + w_step;
                     r_state  <= TRACK;
                  end
               end
               TRACK: begin
                  if (w_evt) begin
                     r_err      <= ERRW'(w_errClamp);
                     r_errSat   <= (w_errClamp != w_errFull);
                     r_errValid <= 1'b1;
                     r_target   <= r_target + w_step;
                     if (r_errValid && !errBus.err_ready) begin
                        r_overrun <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign errBus.err       = r_err;
   assign errBus.err_valid = r_errValid;
   assign errBus.err_sat   = r_errSat;
   assign o_overrun        = r_overrun;
   assign o_locked_state   = r_state;

`ifdef PHASE_FREQ_MEAS_EN
   logic [PHW-1:0]  r_phaseM1;
   logic [ERRW-1:0] r_freqMeas;
   longint          w_freqFull;

   assign w_freqFull = longint'($signed(w_phase - r_phaseM1));

   // The increment is published alongside err so the same err_valid qualifies both.
   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         r_phaseM1  <= '0;
         r_freqMeas <= '0;
      end else begin
         if (w_evt) begin
            r_phaseM1 <= w_phase;
         end
         if (w_evt && i_enable && (r_state == TRACK)) begin
            r_freqMeas <= ERRW'(sat_signed(w_freqFull, ERRW));
         end
      end
   end

   assign o_freq_meas = r_freqMeas;
`else
   assign o_freq_meas = '0;
`endif

endmodule
